// File: rtl/weight_seq_pkg.sv
// Shared defaults and FSM encoding for the weight BRAM sequencer.
package weight_seq_pkg;

    localparam int DEPTH_DEF  = 28;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/weight_bram_sequencer.sv
// Host loads weights into an external BRAM, then streams them in order
// to the MAC with valid/ready flow control; BRAM samples on negedge.
module weight_bram_sequencer
    import weight_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_err,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DI,
    output logic              EN,
    output logic              WE,
    input  logic [DATA_W-1:0] DO,
    output logic              w_valid,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] w_index,
    output logic              w_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    seq_state_e        state;
    logic [ADDR_W-1:0] rd_ptr;
    logic              is_idle;
    logic              addr_ok;
    logic              wr_ok;
    logic              issue;

    assign is_idle = (state == ST_IDLE);
    assign addr_ok = ({1'b0, load_addr} < DEPTH_X);
    assign wr_ok   = !RST && is_idle && load_valid && addr_ok;
    assign issue   = !RST && !abort && (state == ST_READ)
                   && (!w_valid || out_ready);

    assign load_ready = is_idle;
    assign busy       = !is_idle;
    assign EN         = wr_ok || issue;
    assign WE         = wr_ok;
    assign ADDR       = wr_ok ? load_addr : rd_ptr;
    assign DI         = load_data;
    // BRAM holds DO while EN=0, so the stalled word stays on w_data.
    assign w_data     = DO;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            rd_ptr   <= '0;
            w_valid  <= 1'b0;
            w_index  <= '0;
            w_last   <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= is_idle && load_valid && !addr_ok;
            case (state)
                ST_IDLE: begin
                    if (!load_valid && start) begin
                        rd_ptr <= '0;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        w_valid <= 1'b0;
                        w_last  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (issue) begin
                        w_valid <= 1'b1;
                        w_index <= rd_ptr;
                        w_last  <= (rd_ptr == LAST_IDX);
                        if (rd_ptr == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        w_valid <= 1'b0;
                        w_last  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (w_valid && out_ready) begin
                        w_valid <= 1'b0;
                        w_last  <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a negedge BRAM model.
module tb_weight_bram_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        abort;
    logic        load_valid;
    logic [4:0]  load_addr;
    logic [15:0] load_data;
    logic        load_ready;
    logic        load_err;
    logic [4:0]  ADDR;
    logic [15:0] DI;
    logic        EN;
    logic        WE;
    logic [15:0] DO;
    logic        w_valid;
    logic [15:0] w_data;
    logic [4:0]  w_index;
    logic        w_last;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:31];
    int n_cmp = 0;
    int n_bad = 0;

    weight_bram_sequencer dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .load_valid(load_valid), .load_addr(load_addr),
        .load_data(load_data), .load_ready(load_ready),
        .load_err(load_err), .ADDR(ADDR), .DI(DI), .EN(EN), .WE(WE),
        .DO(DO), .w_valid(w_valid), .w_data(w_data), .w_index(w_index),
        .w_last(w_last), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // BRAM model: samples on negedge, DO holds while EN=0
    always @(negedge CLK) begin
        if (EN) begin
            if (WE) mem[ADDR] <= DI;
            else    DO <= mem[ADDR];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 0; abort = 0; load_valid = 0;
        load_addr = '0; load_data = '0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (EN !== 1'b0 || WE !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_en: EN=%b WE=%b want 0 0", EN, WE);
        end
        tick(); tick();
        n_cmp++;
        if ({w_valid, w_index, w_last, done, load_err, busy} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_state: v=%b i=%0d l=%b d=%b e=%b b=%b want 0",
                     w_valid, w_index, w_last, done, load_err, busy);
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: load_ready=%b want 1", load_ready);
        end
    endtask

    task automatic test_preload();
        for (int k = 0; k < 28; k++) begin
            load_valid = 1'b1;
            load_addr  = 5'(k);
            load_data  = 16'h0100 + 16'(k);
            #1;
            if (k == 0 || k == 27) begin
                n_cmp++;
                if (EN !== 1'b1 || WE !== 1'b1 || ADDR !== 5'(k)) begin
                    n_bad++;
                    $display("FAIL preload_ctl: EN=%b WE=%b ADDR=%0d want 1 1 %0d",
                             EN, WE, ADDR, k);
                end
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    // One full pass; toggle gives out_ready pattern 1,0,0,1 repeated
    task automatic run_pass(input bit toggle, input bit hold_start,
                            input string tag);
        int idx = 0;
        bit last_xfer = 0;
        bit seen_done = 0;
        bit was_stall = 0;
        logic [15:0] held_d = '0;
        logic [4:0]  held_i = '0;
        start = 1'b1;
        tick();
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            start = hold_start && !last_xfer;
            out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            #1;
            if (last_xfer) begin
                seen_done = 1;
                n_cmp++;
                if (done !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s done: done=%b v=%b busy=%b want 1 0 0",
                             tag, done, w_valid, busy);
                end
            end else begin
                if (done !== 1'b0 || busy !== 1'b1) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s busy: done=%b busy=%b want 0 1",
                             tag, done, busy);
                end
                if (was_stall) begin
                    n_cmp++;
                    if (w_valid !== 1'b1 || w_index !== held_i
                        || w_data !== held_d) begin
                        n_bad++;
                        $display("FAIL %s hold: v=%b i=%0d d=%h want 1 %0d %h",
                                 tag, w_valid, w_index, w_data, held_i, held_d);
                    end
                end
                was_stall = w_valid && !out_ready;
                held_i = w_index;
                held_d = w_data;
                if (was_stall) begin
                    n_cmp++;
                    if (EN !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s stall_en: EN=%b want 0", tag, EN);
                    end
                end
                if (w_valid && out_ready) begin
                    n_cmp++;
                    if (w_index !== 5'(idx) || w_data !== 16'h0100 + 16'(idx)
                        || w_last !== (idx == 27)) begin
                        n_bad++;
                        $display("FAIL %s word: i=%0d d=%h l=%b want %0d %h %b",
                                 tag, w_index, w_data, w_last, idx,
                                 16'h0100 + 16'(idx), idx == 27);
                    end
                    if (!toggle && cyc != idx + 1) begin
                        n_cmp++; n_bad++;
                        $display("FAIL %s gap: word %0d at cycle %0d want %0d",
                                 tag, idx, cyc, idx + 1);
                    end
                    if (w_last) last_xfer = 1;
                    idx++;
                end
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (idx !== 28 || !seen_done) begin
            n_bad++;
            $display("FAIL %s count: words=%0d done_seen=%b want 28 1",
                     tag, idx, seen_done);
        end
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after: busy=%b done=%b want 0 0", tag, busy, done);
        end
    endtask

    task automatic test_oob_write();
        load_valid = 1'b1;
        load_addr  = 5'd30;
        load_data  = 16'hDEAD;
        #1;
        n_cmp++;
        if (EN !== 1'b0 || load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL oob_en: EN=%b ready=%b want 0 1", EN, load_ready);
        end
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if (load_err !== 1'b1) begin
            n_bad++;
            $display("FAIL oob_err: load_err=%b want 1", load_err);
        end
        tick();
        n_cmp++;
        if (load_err !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_err_pulse: load_err=%b want 0", load_err);
        end
        run_pass(1'b0, 1'b0, "oob_reread");
    endtask

    task automatic test_start_with_load();
        load_valid = 1'b1;
        load_addr  = 5'd3;
        load_data  = 16'h1BEE;
        start      = 1'b1;
        #1;
        n_cmp++;
        if (EN !== 1'b1 || WE !== 1'b1 || ADDR !== 5'd3 || DI !== 16'h1BEE) begin
            n_bad++;
            $display("FAIL sl_ctl: EN=%b WE=%b A=%0d DI=%h want 1 1 3 1bee",
                     EN, WE, ADDR, DI);
        end
        tick();
        load_valid = 1'b0;
        start = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || mem[3] !== 16'h1BEE) begin
            n_bad++;
            $display("FAIL sl_result: busy=%b mem3=%h want 0 1bee", busy, mem[3]);
        end
        load_valid = 1'b1;
        load_data  = 16'h0103;
        tick();
        load_valid = 1'b0;
        run_pass(1'b0, 1'b1, "start_in_read");
    endtask

    task automatic test_abort();
        bit hit = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (w_valid && w_index == 5'd10) begin
                hit = 1;
                abort = 1'b1;
                #1;
                n_cmp++;
                if (EN !== 1'b0) begin
                    n_bad++;
                    $display("FAIL abort_en: EN=%b want 0", EN);
                end
            end
            tick();
        end
        abort = 1'b0;
        n_cmp++;
        if (!hit || w_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_stop: hit=%b v=%b busy=%b want 1 0 0",
                     hit, w_valid, busy);
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (done !== 1'b0 || w_valid !== 1'b0 || EN !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_quiet: done=%b v=%b EN=%b want 0 0 0",
                         done, w_valid, EN);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_pass();
        bit hit = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (w_valid && w_index == 5'd5) begin
                hit = 1;
                RST = 1'b1;
                #1;
                n_cmp++;
                if (EN !== 1'b0 || WE !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rst_mid_en: EN=%b WE=%b want 0 0", EN, WE);
                end
            end
            tick();
        end
        RST = 1'b0;
        n_cmp++;
        if (!hit || {w_valid, w_index, w_last, done, load_err, busy} !== 10'b0
            || load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_state: hit=%b v=%b i=%0d l=%b d=%b b=%b",
                     hit, w_valid, w_index, w_last, done, busy);
        end
        tick();
        run_pass(1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_preload();
        run_pass(1'b0, 1'b0, "stream");
        run_pass(1'b1, 1'b0, "stall");
        test_oob_write();
        test_start_with_load();
        test_abort();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
